// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: frame-aligned breathing brightness envelope for the PWM stage
module pwm_fade_ctrl #(
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64,
  parameter int STEP_SIZE    = 1,
  parameter int MIN_LEVEL    = 0,
  parameter int MAX_LEVEL    = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       one_shot,
  output logic [7:0] brightness,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);
  localparam int SW = $clog2(STEP_PERIODS + 1);
  localparam int HW = $clog2(HOLD_PERIODS + 1);
  localparam logic [7:0] MIN_L = 8'(MIN_LEVEL);
  localparam logic [7:0] MAX_L = 8'(MAX_LEVEL);
  typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;
  state_t state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d, bright_q, bright_d, up_lvl, dn_lvl;
  logic [8:0] up_sum;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic armed_q, armed_d, busy_q, busy_d, done_q, done_d, step_last, hold_last, clr;
  assign frame_tick = frame_cnt_q == 8'hff;
  assign brightness = bright_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    frame_cnt_d = frame_cnt_q + 8'd1;
    up_sum = {1'b0, bright_q} + 9'(STEP_SIZE);
    up_lvl = up_sum >= 9'(MAX_LEVEL) ? MAX_L : up_sum[7:0];
    dn_lvl = {1'b0, bright_q} >= 9'(MIN_LEVEL + STEP_SIZE) ? bright_q - 8'(STEP_SIZE) : MIN_L;
    step_last = step_q == SW'(STEP_PERIODS - 1);
    hold_last = hold_q == HW'(HOLD_PERIODS - 1);
    state_d = state_q;
    bright_d = bright_q;
    step_d = step_q;
    hold_d = hold_q;
    done_d = 1'b0;
    clr = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          bright_d = MIN_L;
          if (enable && armed_q) begin
            state_d = UP;
            step_d = '0;
          end
        end
        UP: begin
          step_d = step_last ? '0 : step_q + 1'b1;
          bright_d = step_last ? up_lvl : bright_q;
          if (step_last && up_lvl == MAX_L) begin
            state_d = HOLD_HI;
            hold_d = '0;
          end
        end
        HOLD_HI: begin
          hold_d = hold_q + 1'b1;
          if (hold_last) begin
            state_d = DOWN;
            step_d = '0;
          end
        end
        DOWN: begin
          step_d = step_last ? '0 : step_q + 1'b1;
          bright_d = step_last ? dn_lvl : bright_q;
          if (step_last && dn_lvl == MIN_L) begin
            state_d = HOLD_LO;
            hold_d = '0;
          end
        end
        HOLD_LO: begin
          hold_d = hold_q + 1'b1;
          if (hold_last) begin
            state_d = (one_shot || !enable) ? IDLE : UP;
            step_d = '0;
            done_d = one_shot || !enable;
            clr = one_shot;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    armed_d = (frame_tick && !enable) ? 1'b1 : clr ? 1'b0 : armed_q;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_q <= '0;
      state_q <= IDLE;
      bright_q <= MIN_L;
      step_q <= '0;
      hold_q <= '0;
      armed_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      state_q <= state_d;
      bright_q <= bright_d;
      step_q <= step_d;
      hold_q <= hold_d;
      armed_q <= armed_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed and randomized checks of pwm_fade_ctrl against a per-frame envelope model
module tb_pwm_fade_ctrl;
  localparam int MIN = 0;
  localparam int MAX = 255;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, one_shot = 1'b0;
  logic [7:0] br_a, br_b;
  logic ft_a, ft_b, busy_a, busy_b, done_a, done_b;
  int checks = 0, errors = 0, fc = 0, n = 0;
  int body[2][64];
  int blen[2], mpos[2], ebr[2];
  bit mbusy[2], marmed[2], edone[2];
  always #5 clk = ~clk;
  pwm_fade_ctrl #(.STEP_PERIODS(1), .HOLD_PERIODS(2), .STEP_SIZE(64)) u_a (
    .CLK(clk), .RST(rst), .enable(enable), .one_shot(one_shot),
    .brightness(br_a), .frame_tick(ft_a), .busy(busy_a), .done(done_a)
  );
  pwm_fade_ctrl #(.STEP_PERIODS(2), .HOLD_PERIODS(3), .STEP_SIZE(200)) u_b (
    .CLK(clk), .RST(rst), .enable(enable), .one_shot(one_shot),
    .brightness(br_b), .frame_tick(ft_b), .busy(busy_b), .done(done_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic build(input int m, input int sp, input int s, input int hp);
    int k = 0;
    int b = MIN;
    while (b < MAX) begin
      repeat (sp - 1) begin body[m][k] = b; k++; end
      b = (b + s > MAX) ? MAX : b + s;
      body[m][k] = b; k++;
    end
    repeat (hp) begin body[m][k] = MAX; k++; end
    while (b > MIN) begin
      repeat (sp - 1) begin body[m][k] = b; k++; end
      b = (b - s < MIN) ? MIN : b - s;
      body[m][k] = b; k++;
    end
    repeat (hp - 1) begin body[m][k] = MIN; k++; end
    blen[m] = k;
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = 1'b0;
      marmed[m] = 1'b1;
      edone[m] = 1'b0;
      ebr[m] = MIN;
      mpos[m] = 0;
    end
  endtask
  task automatic mstep(input int m, input bit en, input bit os);
    bit clr;
    clr = 1'b0;
    edone[m] = 1'b0;
    if (!mbusy[m]) begin
      ebr[m] = MIN;
      if (en && marmed[m]) begin mbusy[m] = 1'b1; mpos[m] = 0; end
    end else if (mpos[m] < blen[m]) begin
      ebr[m] = body[m][mpos[m]];
      mpos[m]++;
    end else begin
      ebr[m] = MIN;
      if (os || !en) begin
        mbusy[m] = 1'b0;
        edone[m] = 1'b1;
        clr = os;
      end else mpos[m] = 0;
    end
    marmed[m] = !en ? 1'b1 : clr ? 1'b0 : marmed[m];
  endtask
  task automatic step();
    @(negedge clk);
    fc = (fc + 1) % 256;
    chk("frame_tick_a", ft_a, fc == 255);
    chk("frame_tick_b", ft_b, fc == 255);
  endtask
  task automatic do_frame(input bit en, input bit os, input bit jit);
    while (fc != 255) begin
      if (jit && $urandom_range(0, 15) == 0) begin
        enable = 1'($urandom);
        one_shot = 1'($urandom);
      end
      if (fc == 128) begin
        chk("mid_frame_br_a", br_a, ebr[0]);
        chk("mid_frame_br_b", br_b, ebr[1]);
      end
      step();
    end
    enable = en;
    one_shot = os;
    step();
    mstep(0, en, os);
    mstep(1, en, os);
    chk("br_a", br_a, ebr[0]);
    chk("br_b", br_b, ebr[1]);
    chk("busy_a", busy_a, mbusy[0]);
    chk("busy_b", busy_b, mbusy[1]);
    chk("done_a", done_a, edone[0]);
    chk("done_b", done_b, edone[1]);
    step();
    chk("done_width_a", done_a, 0);
    chk("done_width_b", done_b, 0);
  endtask
  task automatic go_idle();
    int g = 0;
    do begin
      do_frame(1'b0, 1'b0, 1'b0);
      g++;
    end while ((mbusy[0] || mbusy[1]) && g < 40);
    chk("idle_a", busy_a, 0);
    chk("idle_b", busy_b, 0);
  endtask
  initial begin
    build(0, 1, 64, 2);
    build(1, 2, 200, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fc = 0;
    model_reset();
    chk("rst_br_a", br_a, 0);
    chk("rst_br_b", br_b, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_tick_a", ft_a, 0);
    n = 0;
    while (ft_a !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("tick_latency", n, 255);
    repeat (18) do_frame(1'b1, 1'b1, 1'b0);
    do_frame(1'b0, 1'b0, 1'b0);
    repeat (30) do_frame(1'b1, 1'b0, 1'b0);
    go_idle();
    repeat (3) do_frame(1'b1, 1'b0, 1'b0);
    chk("fade_from_128", br_a, 128);
    repeat (16) do_frame(1'b0, 1'b0, 1'b0);
    chk("fade_done_a", busy_a, 0);
    repeat (40) do_frame($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b1);
    go_idle();
    repeat (5) do_frame(1'b1, 1'b0, 1'b0);
    chk("hold_hi_a", br_a, 255);
    repeat (100) step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_br_a", br_a, 0);
    chk("mid_rst_busy_a", busy_a, 0);
    chk("mid_rst_br_b", br_b, 0);
    chk("mid_rst_busy_b", busy_b, 0);
    rst = 1'b0;
    fc = 0;
    model_reset();
    repeat (16) do_frame(1'b1, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
